// File: rtl/video_overlay_pkg.sv
// Shared types, latency constant and colour blend for the cursor overlay.
// vpix_t is the per-pixel bundle carried between pipeline stages.
package video_overlay_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    rgb_t rgb;
  } vpix_t;

  localparam int OVL_LATENCY = 2;

  localparam vpix_t PIX_IDLE = '{
    hs:    1'b1,
    vs:    1'b1,
    blank: 1'b0,
    rgb:   '0
  };

  function automatic logic [7:0] mix8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8:1];
  endfunction

  function automatic rgb_t blend(
    input rgb_t a,
    input rgb_t b
  );
    rgb_t o;
    o.r = mix8(a.r, b.r);
    o.g = mix8(a.g, b.g);
    o.b = mix8(a.b, b.b);
    return o;
  endfunction

endpackage

// File: rtl/video_if.sv
// Parallel video bundle: active-low syncs, BLANK=1 on active pixels.
// Master drives everything including the pixel clock.
interface video_if;
  import video_overlay_pkg::*;

  logic CLK;
  logic HS;
  logic VS;
  logic BLANK;
  rgb_t RGB;

  modport master (
    output CLK,
    output HS,
    output VS,
    output BLANK,
    output RGB
  );

  modport slave (
    input CLK,
    input HS,
    input VS,
    input BLANK,
    input RGB
  );

endinterface

// File: rtl/video_pos_tracker.sv
// Column/row position of the incoming pixel derived from BLANK and VS edges.
// Edge detectors reset low so the first edge after reset must be real.
module video_pos_tracker #(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int XW    = $clog2(HDISP),
  parameter int YW    = $clog2(VDISP)
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst,
  input  logic          vs,
  input  logic          blank,
  output logic [XW-1:0] x_cnt,
  output logic [YW-1:0] y_cnt,
  output logic          vs_fall
);

  localparam logic [XW-1:0] X_MAX = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(VDISP - 1);

  logic vs_d;
  logic blank_d;
  logic blank_fall;

  assign vs_fall    = vs_d & ~vs;
  assign blank_fall = blank_d & ~blank;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      vs_d    <= 1'b0;
      blank_d <= 1'b0;
    end else begin
      vs_d    <= vs;
      blank_d <= blank;
    end
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      x_cnt <= '0;
    end else if (blank_fall) begin
      x_cnt <= '0;
    end else if (blank && x_cnt != X_MAX) begin
      x_cnt <= x_cnt + 1'b1;
    end
  end

  // Frame start outranks the line advance landing in the same cycle.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      y_cnt <= '0;
    end else if (vs_fall) begin
      y_cnt <= '0;
    end else if (blank_fall && y_cnt != Y_MAX) begin
      y_cnt <= y_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/video_cursor_overlay.sv
// Draws an outlined, half-tinted box cursor over a video stream.
// Cursor settings are latched once per frame at the VS falling edge.
module video_cursor_overlay
  import video_overlay_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int BOX_W = 16,
  parameter int BOX_H = 16
) (
  input  logic                     pixel_clk,
  input  logic                     pixel_rst,
  video_if.slave                   video_ifs,
  video_if.master                  video_ifm,
  input  logic                     cursor_en,
  input  logic [$clog2(HDISP)-1:0] cursor_x,
  input  logic [$clog2(VDISP)-1:0] cursor_y,
  input  logic [23:0]              cursor_rgb
);

  localparam int XW  = $clog2(HDISP);
  localparam int YW  = $clog2(VDISP);
  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;

  localparam logic [XW:0] BW_M1 = XW1'(BOX_W - 1);
  localparam logic [YW:0] BH_M1 = YW1'(BOX_H - 1);

  vpix_t in_px;
  vpix_t s1;
  vpix_t s2;
  vpix_t s1_next;
  vpix_t s2_next;

  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic          vs_fall;

  logic          sh_en;
  logic [XW-1:0] sh_x;
  logic [YW-1:0] sh_y;
  rgb_t          sh_rgb;

  logic [XW:0] x_lo;
  logic [XW:0] x_hi;
  logic [XW:0] x_at;
  logic [YW:0] y_lo;
  logic [YW:0] y_hi;
  logic [YW:0] y_at;

  logic in_x;
  logic in_y;
  logic on_x;
  logic on_y;
  logic hit;
  logic edge_px;
  rgb_t mix;

  assign in_px = '{
    hs:    video_ifs.HS,
    vs:    video_ifs.VS,
    blank: video_ifs.BLANK,
    rgb:   video_ifs.RGB
  };

  video_pos_tracker #(
    .HDISP (HDISP),
    .VDISP (VDISP),
    .XW    (XW),
    .YW    (YW)
  ) u_pos (
    .pixel_clk (pixel_clk),
    .pixel_rst (pixel_rst),
    .vs        (in_px.vs),
    .blank     (in_px.blank),
    .x_cnt     (x_cnt),
    .y_cnt     (y_cnt),
    .vs_fall   (vs_fall)
  );

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      sh_en  <= 1'b0;
      sh_x   <= '0;
      sh_y   <= '0;
      sh_rgb <= '0;
    end else if (vs_fall) begin
      sh_en  <= cursor_en;
      sh_x   <= cursor_x;
      sh_y   <= cursor_y;
      sh_rgb <= cursor_rgb;
    end
  end

  // One extra bit keeps a box near the right/bottom edge from wrapping to 0.
  assign x_lo = {1'b0, sh_x};
  assign x_hi = x_lo + BW_M1;
  assign x_at = {1'b0, x_cnt};
  assign y_lo = {1'b0, sh_y};
  assign y_hi = y_lo + BH_M1;
  assign y_at = {1'b0, y_cnt};

  assign in_x    = (x_at >= x_lo) && (x_at <= x_hi);
  assign in_y    = (y_at >= y_lo) && (y_at <= y_hi);
  assign on_x    = (x_at == x_lo) || (x_at == x_hi);
  assign on_y    = (y_at == y_lo) || (y_at == y_hi);
  assign hit     = sh_en && in_px.blank && in_x && in_y;
  assign edge_px = on_x || on_y;

  always_comb begin
    mix = in_px.rgb;
    unique case (1'b1)
      hit && edge_px:  mix = sh_rgb;
      hit && !edge_px: mix = blend(in_px.rgb, sh_rgb);
      default:         mix = in_px.rgb;
    endcase
  end

  always_comb begin
    s1_next       = in_px;
    s1_next.rgb   = mix;
    s2_next       = s1;
    s2_next.rgb   = s1.blank ? s1.rgb : rgb_t'('0);
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      s1 <= PIX_IDLE;
      s2 <= PIX_IDLE;
    end else begin
      s1 <= s1_next;
      s2 <= s2_next;
    end
  end

  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.HS    = s2.hs;
  assign video_ifm.VS    = s2.vs;
  assign video_ifm.BLANK = s2.blank;
  assign video_ifm.RGB   = s2.rgb;

endmodule

// File: tb/tb_video_cursor_overlay.sv
// Random-pixel stream bench for video_cursor_overlay on a reduced raster.
// A frame-position reference model plus fixed spot values give expectations.
module tb_video_cursor_overlay;
  import video_overlay_pkg::*;

  localparam int HD = 120;
  localparam int VD = 68;
  localparam int BW = 16;
  localparam int BH = 16;
  localparam int HT = HD + 6;
  localparam int VT = VD + 3;
  localparam int XW = $clog2(HD);
  localparam int YW = $clog2(VD);
  localparam logic [26:0] RST_OUT = {1'b1, 1'b1, 1'b0, 24'h0};

  typedef struct {
    logic [26:0] out;
    bit          rs;
    bit          act;
    int          f;
    int          c;
    int          r;
    logic [23:0] din;
  } ent_t;

  typedef struct {
    int          f;
    int          c;
    int          r;
    int          k;
    logic [23:0] v;
  } spot_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [23:0]   crgb;

  video_if vi();
  video_if vo();

  assign vi.CLK = clk;
  always #5 clk = ~clk;

  video_cursor_overlay #(
    .HDISP (HD),
    .VDISP (VD),
    .BOX_W (BW),
    .BOX_H (BH)
  ) dut (
    .pixel_clk  (clk),
    .pixel_rst  (rst),
    .video_ifs  (vi),
    .video_ifm  (vo),
    .cursor_en  (en),
    .cursor_x   (cx),
    .cursor_y   (cy),
    .cursor_rgb (crgb)
  );

  int n_chk = 0;
  int n_pass = 0;
  int rst_left = 0;
  bit rst_prev = 1'b1;

  ent_t  q[$];
  spot_t spots[$];

  bit          m_en = 1'b0;
  int          m_x = 0;
  int          m_y = 0;
  logic [23:0] m_rgb = '0;
  logic [23:0] cur_f5 = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] avg(input logic [7:0] a,
                                     input logic [7:0] b);
    int s;
    s = (int'(a) + int'(b)) / 2;
    return 8'(s);
  endfunction

  function automatic void add_spot(input int f, input int c, input int r,
                                   input int k, input logic [23:0] v);
    spot_t s;
    s.f = f; s.c = c; s.r = r; s.k = k; s.v = v;
    spots.push_back(s);
  endfunction

  // k: 0 fixed colour, 1 unchanged input, 2 cursor colour chosen in frame 5
  task automatic spot(input ent_t e);
    logic [23:0] want;
    if (e.rs || !e.act) return;
    foreach (spots[i]) begin
      if (spots[i].f == e.f && spots[i].c == e.c && spots[i].r == e.r) begin
        want = spots[i].k == 0 ? spots[i].v :
               spots[i].k == 1 ? e.din : cur_f5;
        chk($sformatf("spot f%0d (%0d,%0d)", e.f, e.c, e.r),
            {8'h0, vo.RGB}, {8'h0, want});
      end
    end
  endtask

  task automatic step(input int f, input int r, input int c);
    ent_t e;
    bit act;
    bit hs;
    bit vs;
    bit in_box;
    bit on_edge;
    logic [23:0] d;
    logic [23:0] px;
    @(negedge clk);
    if (q.size() == OVL_LATENCY) begin
      e = q.pop_front();
      chk(e.rs ? "reset out" : $sformatf("pix f%0d r%0d c%0d", e.f, e.r, e.c),
          {5'h0, vo.HS, vo.VS, vo.BLANK, vo.RGB}, {5'h0, e.out});
      spot(e);
    end
    act = (r < VD) && (c < HD);
    hs  = !(c >= HD + 2 && c < HD + 4);
    vs  = (r != VD + 1);
    d   = (f == 1 && act) ? 24'h0000FE : 24'($urandom);
    rst = (rst_left > 0);
    if (rst_left > 0) rst_left--;
    vi.HS = hs;
    vi.VS = vs;
    vi.BLANK = act;
    vi.RGB = d;
    if (rst) begin
      m_en = 1'b0;
    end else if (r == VD + 1 && c == 0) begin
      m_en = en;
      m_x = int'(cx);
      m_y = int'(cy);
      m_rgb = crgb;
    end
    in_box = m_en && act && c >= m_x && c < m_x + BW && r >= m_y && r < m_y + BH;
    on_edge = c == m_x || c == m_x + BW - 1 || r == m_y || r == m_y + BH - 1;
    px = d;
    if (in_box)
      px = on_edge ? m_rgb : {avg(d[23:16], m_rgb[23:16]),
                              avg(d[15:8], m_rgb[15:8]),
                              avg(d[7:0], m_rgb[7:0])};
    e.rs = rst;
    e.act = act;
    e.f = f; e.c = c; e.r = r;
    e.din = d;
    e.out = rst ? RST_OUT : {hs, vs, act, act ? px : 24'h0};
    if (rst && !rst_prev) begin
      foreach (q[i]) begin
        q[i].out = RST_OUT;
        q[i].rs = 1'b1;
      end
    end
    rst_prev = rst;
    q.push_back(e);
  endtask

  initial begin
    en = 1'b0;
    cx = '0;
    cy = '0;
    crgb = '0;
    vi.HS = 1'b1;
    vi.VS = 1'b1;
    vi.BLANK = 1'b0;
    vi.RGB = '0;
    rst_left = 5;

    add_spot(1, 100, 50, 0, 24'hFF0000);
    add_spot(1, 115, 65, 0, 24'hFF0000);
    add_spot(1, 101, 51, 0, 24'h7F007F);
    add_spot(1, 116, 50, 0, 24'h0000FE);
    add_spot(1, 99, 50, 0, 24'h0000FE);
    add_spot(1, 115, 50, 0, 24'hFF0000);
    add_spot(2, 20, 50, 0, 24'hFF0000);
    add_spot(2, 35, 65, 0, 24'hFF0000);
    add_spot(2, 100, 50, 1, 24'h0);
    add_spot(2, 36, 50, 1, 24'h0);
    add_spot(3, HD - 8, VD - 8, 0, 24'hFF0000);
    add_spot(3, HD - 1, VD - 8, 0, 24'hFF0000);
    add_spot(3, HD - 8, VD - 1, 0, 24'hFF0000);
    add_spot(3, 0, VD - 8, 1, 24'h0);
    add_spot(3, 7, VD - 4, 1, 24'h0);
    add_spot(3, HD - 8, 0, 1, 24'h0);
    add_spot(3, 0, 0, 1, 24'h0);
    add_spot(4, 100, 50, 1, 24'h0);
    add_spot(5, 20, 50, 1, 24'h0);
    add_spot(6, 40, 40, 2, 24'h0);
    add_spot(6, 40, 50, 1, 24'h0);
    add_spot(6, 45, 46, 1, 24'h0);
    add_spot(7, 40, 40, 2, 24'h0);
    add_spot(7, 40, 50, 2, 24'h0);
    add_spot(7, 55, 55, 2, 24'h0);

    for (int f = 0; f < 8; f++) begin
      for (int r = 0; r < VT; r++) begin
        for (int c = 0; c < HT; c++) begin
          if (c == 0 && r == VD) begin
            if (f == 0) begin
              en = 1'b1;
              cx = XW'(100);
              cy = YW'(50);
              crgb = 24'hFF0000;
            end
            if (f == 2) begin
              cx = XW'(HD - 8);
              cy = YW'(VD - 8);
            end
            if (f == 3) en = 1'b0;
            if (f == 5) begin
              en = 1'b1;
              cx = XW'(40);
              cy = YW'(40);
              crgb = 24'($urandom);
              cur_f5 = crgb;
            end
          end
          if (f == 1 && r == 30 && c == 0) cx = XW'(20);
          if (f == 6 && r == 45 && c == 10) rst_left = 3;
          step(f, r, c);
        end
      end
    end
    for (int c = 0; c < 3; c++) step(8, VD, HD + c);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/video_cursor_overlay.md
VIDEO_CURSOR_OVERLAY -- requirements
Module: video_cursor_overlay

Interface
REQ-001 SHALL have parameters: HDISP, 800, active pixels per line; VDISP, 480, active lines per frame; BOX_W, 16, cursor width; BOX_H, 16, cursor height.
REQ-002 SHALL have pixel_clk  input  1  pixel clock; all logic runs on it.
REQ-003 SHALL have pixel_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have video_ifs  video_if.slave  bundle  upstream timing/pixel stream (HS, VS active-low; BLANK=1 means active pixel; RGB 24b {R,G,B}).
REQ-005 SHALL have video_ifm  video_if.master  bundle  downstream stream, same encoding; video_ifm.CLK driven by pixel_clk.
REQ-006 SHALL have cursor_en  input  1  overlay enable.
REQ-007 SHALL have cursor_x  input  $clog2(HDISP)  top-left column of box.
REQ-008 SHALL have cursor_y  input  $clog2(VDISP)  top-left row of box.
REQ-009 SHALL have cursor_rgb  input  24  outline colour.

Function
REQ-010 SHALL delay HS, VS and BLANK by exactly 2 pixel_clk cycles; RGB SHALL also have 2-cycle latency, aligned with them.
REQ-011 SHALL sample cursor_en/x/y/rgb into shadow registers only on a VS falling edge (1->0 on input); mid-frame input changes SHALL NOT affect the current frame.
REQ-012 SHALL keep x_cnt = column of the current input pixel: 0 at first active pixel; +1 after each BLANK=1 cycle; cleared on BLANK falling edge; saturates at HDISP-1.
REQ-013 SHALL keep y_cnt = row of current active line: +1 on each BLANK falling edge, saturating at VDISP-1; cleared on VS falling edge; if both occur in one cycle, clear wins.
REQ-014 SHALL compute hit = shadow_en && BLANK && cx<=x_cnt<cx+BOX_W && cy<=y_cnt<cy+BOX_H, with sums taken one bit wider (no wrap); box extending past HDISP/VDISP SHALL be clipped.
REQ-015 SHALL classify a hit pixel as edge when x_cnt==cx, x_cnt==cx+BOX_W-1, y_cnt==cy or y_cnt==cy+BOX_H-1; else interior.
REQ-016 SHALL output: edge -> shadow_rgb; interior -> per-channel (in+shadow)>>1 using 9-bit sums, truncated; non-hit -> input RGB unchanged.
REQ-017 SHALL force output RGB to 0 whenever delayed BLANK is 0.
REQ-018 SHALL pass through unmodified data (only 2-cycle delay) when shadow_en=0.

Reset
REQ-019 SHALL, on pixel_rst, set video_ifm HS=1, VS=1, BLANK=0, RGB=0; x_cnt=0, y_cnt=0; all shadows 0 (overlay off) and pipeline flushed.
REQ-020 SHALL, after release mid-frame, count from 0 but not draw until the first VS falling edge loads shadows.
REQ-021 SHALL treat pixel_rst asynchronously on assertion; no other reset input.

Structure
REQ-022 SHALL place rgb_t (packed 3x8b), OVL_LATENCY=2 and the blend function in shared package video_overlay_pkg.
REQ-023 SHALL isolate x_cnt/y_cnt edge-detect logic in one sub-module video_pos_tracker; hit test, blend and output pipeline stay in top.

Verification
REQ-024 Reset held 5 cycles, released -> outputs HS=1, VS=1, BLANK=0, RGB=0 until input propagates; then output equals input delayed 2 cycles.
REQ-025 cursor_en=1, x=100, y=50, rgb=FF0000, solid input 0000FE -> pixel(100,50)=FF0000, (115,65)=FF0000, (101,51)=7F007F, (116,50)=0000FE, (99,50)=0000FE.
REQ-026 cursor_x=792, cursor_y=472 -> box clipped: edge at (792,472) drawn, columns 792..799 only, no artefact at column 0 or row 0.
REQ-027 Change cursor_x 100->200 at line 240 -> current frame keeps box at 100; next frame at 200.
REQ-028 cursor_en=0, random RGB input for 2 frames -> output bit-exact to input delayed 2 cycles; blanked cycles RGB=0.
REQ-029 Assert pixel_rst 3 cycles at line 300 -> reset values immediately; no box drawn until after next VS falling edge.
